// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator in front of an external fixed-latency multiplier; one result per vector.
// Optional build macro DOT_PRODUCT_SATURATE_EN clamps overflowing sums instead of wrapping them.
module dot_product_accumulator #(
    parameter int wordsize     = 6,
    parameter int mult_latency = 6,
    parameter int acc_extra    = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [wordsize-1:0]                 in_1,
    input  logic [wordsize-1:0]                 in_2,
    output logic [wordsize-1:0]                 mult_in_1,
    output logic [wordsize-1:0]                 mult_in_2,
    output logic                                mult_enable,
    input  logic [2*wordsize-1:0]               mult_out,
    output logic [2*wordsize+acc_extra-1:0]     out,
    output logic                                out_overflow,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int accw = 2*wordsize + acc_extra;

    // Valid/ready: a pair moves on an edge with in_valid && in_ready, a result moves on an
    // edge with out_valid && out_ready; the only stall source is an unconsumed result.
    logic                    w_stall;
    logic                    w_accept;
    logic                    w_head_valid;
    logic                    w_head_last;
    logic [accw:0]           w_sum;
    logic                    w_ovf;
    logic [accw-1:0]         w_result;

    logic [mult_latency-1:0] r_tag_valid;
    logic [mult_latency-1:0] r_tag_last;
    logic [accw-1:0]         r_acc;
    logic                    r_sticky;
    logic [accw-1:0]         r_out;
    logic                    r_out_overflow;
    logic                    r_out_valid;

    assign w_stall     = r_out_valid && !out_ready;
    assign in_ready    = !w_stall;
    assign mult_enable = !w_stall;
    assign w_accept    = in_valid && !w_stall;

    assign mult_in_1 = in_valid ? in_1 : '0;
    assign mult_in_2 = in_valid ? in_2 : '0;

    assign w_head_valid = r_tag_valid[mult_latency-1];
    assign w_head_last  = r_tag_last[mult_latency-1];

    assign w_sum = {1'b0, r_acc} + {{(accw+1-2*wordsize){1'b0}}, mult_out};
    assign w_ovf = w_sum[accw];

`ifdef DOT_PRODUCT_SATURATE_EN
    assign w_result = w_ovf ? {accw{1'b1}} : w_sum[accw-1:0];
`else
    assign w_result = w_sum[accw-1:0];
`endif

    assign out          = r_out;
    assign out_overflow = r_out_overflow;
    assign out_valid    = r_out_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag_valid    <= '0;
            r_tag_last     <= '0;
            r_acc          <= '0;
            r_sticky       <= 1'b0;
            r_out          <= '0;
            r_out_overflow <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Tags advance in lockstep with the multiplier so the head always matches mult_out.
            if (!w_stall) begin
                r_tag_valid <= {r_tag_valid[mult_latency-2:0], w_accept};
                r_tag_last  <= {r_tag_last[mult_latency-2:0], w_accept && in_last};
                if (w_head_valid) begin
                    if (w_head_last) begin
                        r_out          <= w_result;
                        r_out_overflow <= r_sticky || w_ovf;
                        r_out_valid    <= 1'b1;
                        r_acc          <= '0;
                        r_sticky       <= 1'b0;
                    end else begin
                        r_acc    <= w_result;
                        r_sticky <= r_sticky || w_ovf;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomised and directed bench for dot_product_accumulator, with a behavioural multiplier
// and a vector-level scoreboard; runs a wide (acc_extra=4) and a narrow (acc_extra=0) instance.
module tb_dot_product_accumulator;
  localparam int W    = 6;
  localparam int L    = 6;
  localparam int ACCW = 2*W + 4;
  localparam int ACCN = 2*W;
`ifdef DOT_PRODUCT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;
  int   edge_cnt = 0;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  logic           in_valid = 1'b0;
  logic           in_last  = 1'b0;
  logic [W-1:0]   in_1 = '0;
  logic [W-1:0]   in_2 = '0;
  logic           dir_ready  = 1'b1;
  logic           rand_ready = 1'b0;
  logic           rnd_ready  = 1'b1;
  logic           out_ready;
  assign out_ready = rand_ready ? rnd_ready : dir_ready;

  always begin
    @(posedge clk);
    #1 rnd_ready = ($urandom_range(0, 2) != 0);
  end

  logic             in_ready_w, mult_enable_w, out_ovf_w, out_valid_w;
  logic [W-1:0]     mult_in_1_w, mult_in_2_w;
  logic [2*W-1:0]   mult_out_w;
  logic [ACCW-1:0]  out_w;
  logic             in_ready_n, mult_enable_n, out_ovf_n, out_valid_n;
  logic [W-1:0]     mult_in_1_n, mult_in_2_n;
  logic [2*W-1:0]   mult_out_n;
  logic [ACCN-1:0]  out_n;

  dot_product_accumulator #(.wordsize(W), .mult_latency(L), .acc_extra(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
    .in_1(in_1), .in_2(in_2), .mult_in_1(mult_in_1_w), .mult_in_2(mult_in_2_w),
    .mult_enable(mult_enable_w), .mult_out(mult_out_w), .out(out_w), .out_overflow(out_ovf_w),
    .out_valid(out_valid_w), .out_ready(out_ready)
  );

  dot_product_accumulator #(.wordsize(W), .mult_latency(L), .acc_extra(0)) dut_narrow (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n), .in_last(in_last),
    .in_1(in_1), .in_2(in_2), .mult_in_1(mult_in_1_n), .mult_in_2(mult_in_2_n),
    .mult_enable(mult_enable_n), .mult_out(mult_out_n), .out(out_n), .out_overflow(out_ovf_n),
    .out_valid(out_valid_n), .out_ready(out_ready)
  );

  // behavioural multipliers: L enabled edges from sampling to product
  logic [2*W-1:0] pipe_w [L];
  logic [2*W-1:0] pipe_n [L];
  assign mult_out_w = pipe_w[L-1];
  assign mult_out_n = pipe_n[L-1];
  always @(posedge clk) begin
    if (mult_enable_w) begin
      for (int i = L-1; i > 0; i--) pipe_w[i] <= pipe_w[i-1];
      pipe_w[0] <= (2*W)'(mult_in_1_w) * (2*W)'(mult_in_2_w);
    end
    if (mult_enable_n) begin
      for (int i = L-1; i > 0; i--) pipe_n[i] <= pipe_n[i-1];
      pipe_n[0] <= (2*W)'(mult_in_1_n) * (2*W)'(mult_in_2_n);
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int unsigned     prods[$];
  logic [ACCW:0]   exp_q[$];
  logic [ACCN:0]   exp_n_q[$];
  int              exp_t_q[$];
  logic [ACCW:0]   cur_w = '0;
  logic [ACCN:0]   cur_n = '0;
  int              stall_cnt = 0;
  logic            prev_valid = 1'b0;
  logic            xfer_pend  = 1'b0;

  // Dot product of the pending vector in a `width`-bit accumulator; returns {overflow, value}.
  function automatic logic [32:0] dot(input int width);
    longint acc = 0;
    longint lim = longint'(1) << width;
    bit     ovf = 1'b0;
    foreach (prods[i]) begin
      acc = acc + longint'(prods[i]);
      if (acc >= lim) begin
        ovf = 1'b1;
        acc = SAT ? lim - 1 : acc - lim;
      end
    end
    return {ovf, acc[31:0]};
  endfunction

  always @(negedge clk) begin
    logic        new_res;
    logic        stall;
    logic [32:0] r;
    if (!reset) begin
      prods.delete();
      prev_valid = 1'b0;
      xfer_pend  = 1'b0;
    end else begin
      new_res = out_valid_w && (!prev_valid || xfer_pend);
      if (new_res) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_w), 32'hFFFF_FFFF);
        end else begin
          cur_w = exp_q.pop_front();
          cur_n = exp_n_q.pop_front();
          check("out", 32'(out_w), 32'(cur_w[ACCW-1:0]));
          check("out_overflow", 32'(out_ovf_w), 32'(cur_w[ACCW]));
          check("narrow_valid", 32'(out_valid_n), 32'd1);
          check("narrow_out", 32'(out_n), 32'(cur_n[ACCN-1:0]));
          check("narrow_overflow", 32'(out_ovf_n), 32'(cur_n[ACCN]));
          check("latency", edge_cnt - stall_cnt, exp_t_q.pop_front());
        end
      end else if (out_valid_w) begin
        check("hold_out", 32'(out_w), 32'(cur_w[ACCW-1:0]));
        check("hold_narrow_out", 32'(out_n), 32'(cur_n[ACCN-1:0]));
      end
      stall = out_valid_w && !out_ready;
      if (stall) stall_cnt++;
      check("in_ready", 32'(in_ready_w), 32'(!stall));
      check("mult_enable", 32'(mult_enable_w), 32'(!stall));
      if (!in_valid) check("mult_in_zero", 32'({mult_in_1_w, mult_in_2_w}), 32'd0);
      if (in_valid && in_ready_w) begin
        prods.push_back(32'(in_1) * 32'(in_2));
        if (in_last) begin
          r = dot(ACCW);
          exp_q.push_back(r[32] ? {1'b1, r[ACCW-1:0]} : {1'b0, r[ACCW-1:0]});
          r = dot(ACCN);
          exp_n_q.push_back({r[32], r[ACCN-1:0]});
          exp_t_q.push_back(edge_cnt + 1 - stall_cnt + L);
          prods.delete();
        end
      end
      xfer_pend  = out_valid_w && out_ready;
      prev_valid = out_valid_w;
    end
  end

  // driver tasks: entered and left at posedge + 1
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_1 = a;
    in_2 = b;
    in_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready_w) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_1 = W'($urandom_range(0, 63));
    in_2 = W'($urandom_range(0, 63));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    return ($urandom_range(0, 3) == 0) ? W'(63) : W'($urandom_range(0, 63));
  endfunction

  initial begin
    logic drained;
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_w), 32'd0);
    check("rst_out", 32'(out_w), 32'd0);
    check("rst_out_overflow", 32'(out_ovf_w), 32'd0);
    check("rst_in_ready", 32'(in_ready_w), 32'd1);
    check("rst_mult_enable", 32'(mult_enable_w), 32'd1);
    idle(3);
    check("idle_out_valid", 32'(out_valid_w), 32'd0);

    send(6'd1, 6'd10, 1'b0);
    send(6'd10, 6'd12, 1'b0);
    send(6'd60, 6'd40, 1'b1);
    idle(L + 3);

    send(6'd3, 6'd4, 1'b1);
    send(6'd5, 6'd5, 1'b0);
    send(6'd2, 6'd2, 1'b1);
    idle(L + 3);

    dir_ready = 1'b0;
    send(6'd3, 6'd4, 1'b1);
    send(6'd7, 6'd9, 1'b1);
    idle(L + 4);
    check("bp_in_ready", 32'(in_ready_w), 32'd0);
    check("bp_mult_enable", 32'(mult_enable_w), 32'd0);
    check("bp_out_held", 32'(out_w), 32'd12);
    dir_ready = 1'b1;
    idle(L + 3);

    send(6'd63, 6'd63, 1'b0);
    send(6'd63, 6'd63, 1'b1);
    idle(L + 3);

    send(6'd20, 6'd20, 1'b0);
    idle(2);
    do_reset();
    idle(L + 2);
    check("rst_no_result", 32'(out_valid_w), 32'd0);
    send(6'd2, 6'd3, 1'b1);
    idle(L + 3);

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rand_op(), rand_op(), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    send(rand_op(), rand_op(), 1'b1);
    rand_ready = 1'b0;
    dir_ready  = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 300; i++) begin
      idle(1);
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle(L + 2);
    check("final_out_valid", 32'(out_valid_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
